// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch symbol conditioner.
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ERR  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int N_CH_DEF = 4;
  localparam int SYM_W    = 2;

  function automatic int unsigned onehot_count(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: two-flop synchroniser followed by a
// run-length debouncer on the synchronised level.
module sw_debounce_ch
  import switch_pkg::*;
#(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  logic             q1_q, q1_d;
  logic             q2_q, q2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  always_comb begin
    q1_d     = raw;
    q2_d     = q1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (q2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = q2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q1_q     <= 1'b0;
      q2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      q1_q     <= q1_d;
      q2_q     <= q2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/switch_symbol_conditioner.sv
// Turns raw slide switches into one one-hot symbol per
// press-and-release gesture, flagging multi-switch gestures.
module switch_symbol_conditioner
  import switch_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  sw_raw,
  output logic             sym_valid,
  output logic [N_CH-1:0]  sym_onehot,
  output logic [SYM_W-1:0] sym_code,
  output logic             multi_err,
  output logic [N_CH-1:0]  sw_stable,
  output logic             busy
);

  logic [N_CH-1:0] stable_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_debounce_ch #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_raw[i]),
      .stable(stable_w[i])
    );
  end

  state_e           state_q;
  logic             sym_valid_q;
  logic [N_CH-1:0]  sym_onehot_q;
  logic [SYM_W-1:0] sym_code_q;
  logic             multi_err_q;
  logic             busy_q;

  int unsigned      act_cnt;
  logic [SYM_W-1:0] sel_idx;

  always_comb begin
    act_cnt = onehot_count(32'(stable_w));
    sel_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (stable_w[i]) sel_idx = SYM_W'(i);
    end
  end

  // Strobes default low each cycle; HOLD waits for full release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sym_valid_q  <= 1'b0;
      sym_onehot_q <= '0;
      sym_code_q   <= '0;
      multi_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sym_valid_q  <= 1'b0;
      sym_onehot_q <= '0;
      multi_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (act_cnt == 1) begin
            state_q      <= EMIT;
            sym_valid_q  <= 1'b1;
            sym_onehot_q <= stable_w;
            sym_code_q   <= sel_idx;
            busy_q       <= 1'b1;
          end else if (act_cnt > 1) begin
            state_q     <= ERR;
            multi_err_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        EMIT: state_q <= HOLD;
        ERR:  state_q <= HOLD;
        HOLD: begin
          if (stable_w == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign sym_valid  = sym_valid_q;
  assign sym_onehot = sym_onehot_q;
  assign sym_code   = sym_code_q;
  assign multi_err  = multi_err_q;
  assign sw_stable  = stable_w;
  assign busy       = busy_q;

endmodule

// File: tb/tb_switch_symbol_conditioner.sv
// Bench for switch_symbol_conditioner: directed gestures plus
// random switch activity against a window-based gesture model.
module tb_switch_symbol_conditioner;

  localparam int DB = 8;
  localparam int HN = 8192;

  logic       clk;
  logic       reset;
  logic [3:0] sw_raw;
  logic       sym_valid;
  logic [3:0] sym_onehot;
  logic [1:0] sym_code;
  logic       multi_err;
  logic [3:0] sw_stable;
  logic       busy;

  switch_symbol_conditioner #(
    .N_CH     (4),
    .DB_CYCLES(DB),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .sym_valid (sym_valid),
    .sym_onehot(sym_onehot),
    .sym_code  (sym_code),
    .multi_err (multi_err),
    .sw_stable (sw_stable),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Model state: raw sample history per edge, last change edge per channel.
  logic [3:0] hist [HN];
  int         last_chg [4];
  int         n;
  int         g_edge;
  logic       m_idle;
  logic [3:0] m_stable, m_oh;
  logic [1:0] m_code;
  logic       m_valid, m_err, m_busy;

  int         valid_cnt, err_cnt, last_valid_edge;

  task automatic model_edge(input logic [3:0] r, input logic rs);
    logic [3:0] pre;
    int         pc;
    bit         all_diff;
    n++;
    if (rs) begin
      hist[n]     = '0;
      hist[n - 1] = '0;
      m_stable    = '0;
      for (int c = 0; c < 4; c++) last_chg[c] = n;
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_oh    = '0;
      m_code  = '0;
      m_busy  = 1'b0;
    end else begin
      pre = m_stable;
      // Stable flips once the synchronised level has differed for DB edges.
      for (int c = 0; c < 4; c++) begin
        if (n - last_chg[c] >= DB) begin
          all_diff = 1'b1;
          for (int j = 0; j < DB; j++)
            if (hist[n - 2 - j][c] == pre[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[c] = ~pre[c];
            last_chg[c] = n;
          end
        end
      end
      hist[n] = r;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_oh    = '0;
      pc      = $countones(pre);
      if (m_idle) begin
        if (pc == 1) begin
          m_valid = 1'b1;
          m_oh    = pre;
          m_code  = 2'($clog2(pre));
          m_busy  = 1'b1;
          m_idle  = 1'b0;
          g_edge  = n;
        end else if (pc > 1) begin
          m_err  = 1'b1;
          m_busy = 1'b1;
          m_idle = 1'b0;
          g_edge = n;
        end
      end else if (n >= g_edge + 2 && pre == 4'b0) begin
        m_idle = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rs);
    sw_raw = r;
    reset  = rs;
    @(posedge clk);
    #1;
    model_edge(r, rs);
    chk("sym_valid", 32'(sym_valid), 32'(m_valid));
    chk("multi_err", 32'(multi_err), 32'(m_err));
    chk("sym_onehot", 32'(sym_onehot), 32'(m_oh));
    chk("sym_code", 32'(sym_code), 32'(m_code));
    chk("sw_stable", 32'(sw_stable), 32'(m_stable));
    chk("busy", 32'(busy), 32'(m_busy));
    if (sym_valid) begin
      chk("one_hot", 32'($countones(sym_onehot)), 32'd1);
      valid_cnt++;
      last_valid_edge = n;
    end
    if (multi_err) err_cnt++;
  endtask

  task automatic hold(input logic [3:0] r, input int cyc);
    for (int k = 0; k < cyc; k++) step(r, 1'b0);
  endtask

  int v0, e0, r_edge, t0, dur;
  logic [3:0] rv;
  bit found;

  initial begin
    for (int i = 0; i < HN; i++) hist[i] = '0;
    for (int c = 0; c < 4; c++) last_chg[c] = 0;
    n = 8; g_edge = 0;
    m_idle = 1'b1; m_stable = '0; m_oh = '0; m_code = '0;
    m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    valid_cnt = 0; err_cnt = 0; last_valid_edge = 0;
    sw_raw = '0; reset = 1'b1;

    // Held switch through reset, emits at edge 11 after release.
    for (int k = 0; k < 3; k++) step(4'b0010, 1'b1);
    chk("rst_valid", 32'(sym_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    r_edge = n; v0 = valid_cnt;
    hold(4'b0010, 20);
    chk("s1_cnt", 32'(valid_cnt - v0), 32'd1);
    chk("s1_edge", 32'(last_valid_edge - r_edge), 32'd11);
    hold(4'b0000, 20);

    // Short glitch never debounces.
    v0 = valid_cnt;
    hold(4'b0001, 5);
    hold(4'b0000, 20);
    chk("s2_cnt", 32'(valid_cnt - v0), 32'd0);
    chk("s2_busy", 32'(busy), 32'd0);

    // Press, release, press again: two symbols, no repeats.
    v0 = valid_cnt; t0 = n;
    hold(4'b0100, 40);
    chk("s3_edge1", 32'(last_valid_edge - t0), 32'd11);
    hold(4'b0000, 30);
    t0 = n;
    hold(4'b0100, 40);
    chk("s3_edge2", 32'(last_valid_edge - t0), 32'd11);
    chk("s3_code", 32'(sym_code), 32'd2);
    hold(4'b0000, 30);
    chk("s3_cnt", 32'(valid_cnt - v0), 32'd2);

    // Simultaneous two-switch press.
    v0 = valid_cnt; e0 = err_cnt;
    hold(4'b1001, 30);
    chk("s4_busy", 32'(busy), 32'd1);
    hold(4'b0000, 30);
    chk("s4_err", 32'(err_cnt - e0), 32'd1);
    chk("s4_valid", 32'(valid_cnt - v0), 32'd0);
    chk("s4_idle", 32'(busy), 32'd0);

    // Staggered press: first switch wins.
    v0 = valid_cnt; e0 = err_cnt;
    hold(4'b0010, 3);
    hold(4'b1010, 30);
    chk("s5_code", 32'(sym_code), 32'd1);
    hold(4'b0000, 30);
    chk("s5_valid", 32'(valid_cnt - v0), 32'd1);
    chk("s5_err", 32'(err_cnt - e0), 32'd0);

    // Reset during the emit cycle, then re-emit.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(4'b0100, 1'b0);
      if (sym_valid) found = 1'b1;
    end
    chk("s6_found", 32'(found), 32'd1);
    step(4'b0100, 1'b1);
    chk("s6_drop", 32'(sym_valid), 32'd0);
    r_edge = n; v0 = valid_cnt;
    hold(4'b0100, 20);
    chk("s6_cnt", 32'(valid_cnt - v0), 32'd1);
    chk("s6_edge", 32'(last_valid_edge - r_edge), 32'(DB + 3));
    hold(4'b0000, 20);

    // Random switch activity with occasional resets.
    for (int b = 0; b < 150; b++) begin
      case ($urandom_range(0, 3))
        0: rv = 4'b0000;
        1: rv = 4'b0001 << $urandom_range(0, 3);
        default: rv = 4'($urandom);
      endcase
      dur = $urandom_range(1, 22);
      if ($urandom_range(0, 29) == 0) step(rv, 1'b1);
      hold(rv, dur);
    end
    hold(4'b0000, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/switch_symbol_conditioner.md
Name: switch_symbol_conditioner

Overview:
- Front-end stage for the lock-sequence FSM: conditions the four raw slide-switch inputs (S1..S4) before they reach it.
- Per switch: synchronises, then debounces.
- Emits at most one single-cycle, one-hot symbol per press-and-release gesture.
- Flags gestures in which more than one switch became active at once.
- Outputs replace direct switch-to-FSM wiring: sym_onehot feeds the FSM S1..S4 inputs; sym_valid marks the cycle in which they are meaningful.

Parameters:
- N_CH, 4, number of switch channels (fixed at 4 for the FSM; parameterised for reuse).
- DB_CYCLES, 8, consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates; legal range 2..2**CNT_W.
- CNT_W, 4, width of the per-channel debounce counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- sw_raw  in  N_CH  asynchronous raw switch levels; bit i is switch S(i+1).
- sym_valid  out  1  one-cycle strobe: a valid symbol is present.
- sym_onehot  out  N_CH  one-hot symbol; nonzero only while sym_valid=1.
- sym_code  out  2  index of the last emitted channel; holds until the next emit.
- multi_err  out  1  one-cycle strobe: more than one debounced switch was active when leaving IDLE.
- sw_stable  out  N_CH  debounced switch levels (for LEDs/debug).
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, at the edge with reset=1):
  - Synchroniser flops, debounce counters, sw_stable, sym_valid, sym_onehot, sym_code, multi_err and busy all go to 0.
  - State goes to IDLE.
  - Reset has priority over every other event and aborts any pending emit, error or hold.
- Synchroniser: two flops per channel (q1, q2).
- Debounce, per channel, at each edge:
  - If q2 == sw_stable[i]: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: sw_stable[i] <= q2 and cnt <= 0.
  - Else: cnt <= cnt + 1.
  - A pulse or glitch shorter than DB_CYCLES cycles after sync never changes sw_stable.
- Channels are fully independent.
- State machine (registered outputs):
  - IDLE:
    - sw_stable == 0: stay.
    - Exactly one bit set: go to EMIT. In the same edge, load sym_onehot = sw_stable, sym_code = bit index, sym_valid = 1.
    - Two or more bits set: go to ERR with multi_err = 1.
  - EMIT (one cycle): sym_valid and sym_onehot clear at the next edge; go to HOLD.
  - ERR (one cycle): multi_err clears at the next edge; go to HOLD.
  - HOLD: all switch activity is ignored until sw_stable == 0, then go to IDLE. A new symbol needs full release first, so holding S1 never repeats.
- Latency: a clean step on sw_raw[i] from IDLE gives sym_valid high in the cycle after edge 2+DB_CYCLES+1 (edge 11 at default), counted from the first edge that samples the new level.
- Boundary cases:
  - Two channels stabilising on the same edge: ERR, no symbol emitted.
  - Channels stabilising on different edges: the first one is emitted; later ones are absorbed in HOLD.
  - Release and re-press inside HOLD before sw_stable reaches 0: no emit.
  - A switch held through reset de-assertion is re-debounced from sw_stable=0, so it emits one symbol DB_CYCLES+3 edges after reset falls.
  - sym_valid and multi_err are never high in the same cycle.
  - sym_onehot always has popcount 0 or 1.

Decomposition:
- Shared package switch_pkg:
  - typedef enum for states {IDLE, EMIT, ERR, HOLD} (2 bits).
  - localparams N_CH_DEF=4, SYM_W=2.
  - Function onehot_count returning the popcount of an N_CH vector.
- Sub-module sw_debounce_ch: 2-flop synchroniser plus counter for one channel. Ports: clk, reset, raw, stable. Parameters: DB_CYCLES, CNT_W. Instantiated N_CH times by generate.

Test Plan:
- Reset held 3 cycles with sw_raw=4'b0010 → all outputs 0 during reset. After release, sym_valid=1 for exactly one cycle at edge 11, with sym_onehot=4'b0010, sym_code=1, busy=1.
- sw_raw[0] glitches high for 5 cycles (DB_CYCLES=8) from IDLE → sw_stable stays 0, no sym_valid, busy stays 0.
- sw_raw=4'b0100 held 40 cycles, then released, then held again → exactly two sym_valid pulses with sym_code=2, each 11 edges after its press edge; no repeats while held.
- sw_raw goes 0→4'b1001 on one edge → multi_err=1 for one cycle at edge 11, no sym_valid, HOLD until both released, then busy=0.
- sw_raw[1] rises, then sw_raw[3] rises 3 cycles later → one sym_valid with sym_code=1, no multi_err, no second symbol until all released.
- reset pulsed for 1 cycle during the EMIT cycle → sym_valid drops at that edge, state IDLE, counters 0, and the held switch re-emits after DB_CYCLES+3 edges.
